hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Combined forwarding and hazard controller for the 5-stage MIPS pipeline; the parametrised successor to the two-operand forwarding unit.
- Generates per-operand forward selects for NUM_SRC source operands, with correct EX/MEM-over-MEM/WB priority.
- Detects load-use hazards.
- Runs a stall FSM for the multi-cycle multiply unit.
- Maintains a saturating stall-cycle performance counter.
- Sits beside the ID/EX register and drives the PC, IF/ID and ID/EX enable/flush controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction (1..4)
MUL_STALL, 4, stall cycles per multiply (>=2)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
ex_mem_regwrite  input  1  EX/MEM instruction writes the register file
ex_mem_rd  input  REG_AW  EX/MEM destination register
mem_wb_regwrite  input  1  MEM/WB instruction writes the register file
mem_wb_rd  input  REG_AW  MEM/WB destination register
id_ex_src  input  NUM_SRC*REG_AW  ID/EX source registers; operand i at bits [i*REG_AW +: REG_AW]
id_ex_memread  input  1  ID/EX instruction is a load
id_ex_rd  input  REG_AW  ID/EX destination register
id_ex_mul  input  1  ID/EX instruction is a multiply
if_id_src  input  NUM_SRC*REG_AW  IF/ID source registers, same packing
if_id_src_used  input  NUM_SRC  per-operand "operand actually read"
forward_sel  output  2*NUM_SRC  operand i select at [2i +: 2]: 00 register file, 10 EX/MEM, 01 MEM/WB
stall_pc  output  1  hold PC
stall_if_id  output  1  hold IF/ID
flush_id_ex  output  1  insert bubble into ID/EX
ex_hold  output  1  freeze ID/EX and EX/MEM (multiply in progress)
mul_busy  output  1  FSM in BUSY
stall_cycles  output  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
Forward selects (combinational, per operand i, with s = id_ex_src[i]):
- 10 if ex_mem_regwrite, ex_mem_rd!=0 and ex_mem_rd==s.
- Otherwise 01 if mem_wb_regwrite, mem_wb_rd!=0 and mem_wb_rd==s.
- Otherwise 00.
- A MEM/WB non-match never clears an EX/MEM match.
- Register 0 is never forwarded.

Load-use detect (combinational):
- lu=1 when id_ex_memread, id_ex_rd!=0, and any i has if_id_src_used[i]=1 with if_id_src[i]==id_ex_rd.

Multiply FSM:
- States IDLE, BUSY; registers cnt, done (1 bit).
- mstart = IDLE and id_ex_mul and !done.
- IDLE with mstart: next BUSY, cnt <= MUL_STALL-2.
- IDLE without mstart: done <= 0.
- BUSY with cnt==0: next IDLE, done <= 1.
- BUSY with cnt!=0: cnt <= cnt-1.
- done suppresses retrigger of the same multiply in the cycle it leaves EX.
- Result: exactly MUL_STALL stall cycles per multiply (the mstart cycle plus MUL_STALL-1 BUSY cycles).

Outputs:
- mul_busy = (state==BUSY).
- ex_hold = mstart or mul_busy.
- stall_pc = stall_if_id = ex_hold or lu.
- flush_id_ex = lu and !ex_hold. A held instruction is never flushed; a load-use is re-evaluated once the hold drops.

Counter:
- stall_cycles increments on each rising edge where stall_pc=1.
- Saturates at all-ones; no wrap.

Reset:
- rst=1 forces, asynchronously at any time including mid-BUSY: state IDLE, cnt 0, done 0, stall_cycles 0.
- With idle inputs, all outputs are then 0.
- After rst deasserts, a multiply still present in ID/EX restarts a full MUL_STALL sequence.

Test Plan:
1. ex_mem_regwrite=1, ex_mem_rd=8, mem_wb_regwrite=1, mem_wb_rd=8, id_ex_src={8,9} -> forward_sel operand0=10, operand1=00. Then mem_wb_rd=9 -> operand1=01, operand0 stays 10.
2. ex_mem_rd=0 with regwrite=1, id_ex_src operand0=0 -> forward_sel=00. NUM_SRC=3 build: each operand selects independently.
3. id_ex_memread=1, id_ex_rd=5, if_id_src operand1=5 with used=1 -> stall_pc=stall_if_id=flush_id_ex=1 for one cycle, stall_cycles +1. Same case with used=0 -> no stall.
4. MUL_STALL=4, id_ex_mul=1 held -> ex_hold=1 for exactly 4 cycles, mul_busy=1 on cycles 2-4, stall_cycles=4. Cycle 5: all stalls 0 and no retrigger. Back-to-back multiplies -> second starts the cycle after done clears.
5. Load-use condition present during a multiply -> flush_id_ex=0 while ex_hold=1. Flush occurs in the first cycle after the hold drops if the hazard persists.
6. Assert rst in 2nd BUSY cycle -> mul_busy, ex_hold and stall_cycles go to 0 immediately. CNT_W=3 with a continuous stall -> stall_cycles holds 7.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - forwarding, load-use and multiply-stall control for the 5-stage pipeline
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   ex_mem_regwrite/rd       writeback info of the EX/MEM instruction
//   mem_wb_regwrite/rd       writeback info of the MEM/WB instruction
//   id_ex_src/memread/rd/mul operands and type of the instruction in EX
//   if_id_src/src_used       operands of the instruction in ID
//   forward_sel              per-operand select: 10 EX/MEM, 01 MEM/WB, 00 register file
//   stall_pc, stall_if_id    hold PC and IF/ID
//   flush_id_ex              insert a bubble into ID/EX
//   ex_hold, mul_busy        multiply in progress / FSM in BUSY
//   stall_cycles             saturating count of cycles with stall_pc=1
module hazard_forward_ctrl #(
   parameter int REG_AW    = 5,
   parameter int NUM_SRC   = 2,
   parameter int MUL_STALL = 4,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ex_mem_regwrite,
   input  logic [REG_AW-1:0]         ex_mem_rd,
   input  logic                      mem_wb_regwrite,
   input  logic [REG_AW-1:0]         mem_wb_rd,
   input  logic [NUM_SRC*REG_AW-1:0] id_ex_src,
   input  logic                      id_ex_memread,
   input  logic [REG_AW-1:0]         id_ex_rd,
   input  logic                      id_ex_mul,
   input  logic [NUM_SRC*REG_AW-1:0] if_id_src,
   input  logic [NUM_SRC-1:0]        if_id_src_used,
   output logic [2*NUM_SRC-1:0]      forward_sel,
   output logic                      stall_pc,
   output logic                      stall_if_id,
   output logic                      flush_id_ex,
   output logic                      ex_hold,
   output logic                      mul_busy,
   output logic [CNT_W-1:0]          stall_cycles
);

   localparam int CW = (MUL_STALL > 2) ? $clog2(MUL_STALL - 1) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          done, done_next;
   logic          mstart;
   logic          lu;

   // EX/MEM is tested first so a younger result always wins over MEM/WB.
   always_comb begin
      forward_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_mem_regwrite && (ex_mem_rd != '0) &&
             (ex_mem_rd == id_ex_src[i*REG_AW +: REG_AW]))
            forward_sel[2*i +: 2] = 2'b10;
         else if (mem_wb_regwrite && (mem_wb_rd != '0) &&
                  (mem_wb_rd == id_ex_src[i*REG_AW +: REG_AW]))
            forward_sel[2*i +: 2] = 2'b01;
      end
   end

   always_comb begin
      lu = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (if_id_src_used[i] && (if_id_src[i*REG_AW +: REG_AW] == id_ex_rd))
            lu = 1'b1;
      end
      if (!id_ex_memread || (id_ex_rd == '0))
         lu = 1'b0;
   end

   // done blocks a restart in the cycle the finished multiply is still in EX.
   // rst gates mstart so no stall is requested while the controller is held in reset.
   assign mstart = (state == IDLE) && id_ex_mul && !done && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_next  = done;
      case (state)
         IDLE: begin
            if (mstart) begin
               state_next = BUSY;
               cnt_next   = CW'(MUL_STALL - 2);
            end else begin
               done_next = 1'b0;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
      endcase
   end

   assign mul_busy    = (state == BUSY);
   assign ex_hold     = mstart || mul_busy;
   assign stall_pc    = ex_hold || lu;
   assign stall_if_id = stall_pc;
   // A held instruction must stay in ID/EX; the hazard is re-checked once the hold drops.
   assign flush_id_ex = lu && !ex_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall_pc && (stall_cycles != '1))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

   localparam int AW = 5;
   localparam int MS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1;
   logic            ex_mem_regwrite, mem_wb_regwrite, id_ex_memread, id_ex_mul;
   logic [AW-1:0]   ex_mem_rd, mem_wb_rd, id_ex_rd;
   logic [2*AW-1:0] id_ex_src, if_id_src;
   logic [1:0]      if_id_src_used;
   logic [3*AW-1:0] id_ex_src3, if_id_src3;
   logic [2:0]      if_id_src_used3;

   logic [3:0]  forward_sel;
   logic        stall_pc, stall_if_id, flush_id_ex, ex_hold, mul_busy;
   logic [15:0] stall_cycles;
   logic [5:0]  forward_sel3;
   logic        stall_pc3, stall_if_id3, flush_id_ex3, ex_hold3, mul_busy3;
   logic [2:0]  stall_cycles3;

   hazard_forward_ctrl #(.REG_AW(AW), .NUM_SRC(2), .MUL_STALL(MS), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
      .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
      .id_ex_src(id_ex_src), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .id_ex_mul(id_ex_mul), .if_id_src(if_id_src), .if_id_src_used(if_id_src_used),
      .forward_sel(forward_sel), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .flush_id_ex(flush_id_ex), .ex_hold(ex_hold), .mul_busy(mul_busy),
      .stall_cycles(stall_cycles)
   );

   hazard_forward_ctrl #(.REG_AW(AW), .NUM_SRC(3), .MUL_STALL(MS), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst),
      .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
      .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
      .id_ex_src(id_ex_src3), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .id_ex_mul(id_ex_mul), .if_id_src(if_id_src3), .if_id_src_used(if_id_src_used3),
      .forward_sel(forward_sel3), .stall_pc(stall_pc3), .stall_if_id(stall_if_id3),
      .flush_id_ex(flush_id_ex3), .ex_hold(ex_hold3), .mul_busy(mul_busy3),
      .stall_cycles(stall_cycles3)
   );

   int checks = 0;
   int errors = 0;

   // reference model: multiply tracked as remaining BUSY cycles plus "just finished" flag
   int m_busy_left, m_done, m_cnt, m_cnt3;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [AW-1:0] s);
      if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == s) return 2'b10;
      if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == s) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [7:0] fwd_of(input logic [4*AW-1:0] src, input int n);
      logic [7:0] r = '0;
      for (int i = 0; i < n; i++) r[2*i +: 2] = ref_fwd(src[i*AW +: AW]);
      return r;
   endfunction

   function automatic logic lu_of(input logic [4*AW-1:0] src, input logic [3:0] used, input int n);
      logic hit = 1'b0;
      for (int i = 0; i < n; i++)
         if (used[i] && src[i*AW +: AW] == id_ex_rd) hit = 1'b1;
      return hit && id_ex_memread && (id_ex_rd != 0);
   endfunction

   function automatic logic ref_start();
      return !rst && (m_busy_left == 0) && id_ex_mul && (m_done == 0);
   endfunction

   function automatic logic ref_hold();
      return ref_start() || (m_busy_left > 0);
   endfunction

   task automatic model_reset();
      m_busy_left = 0; m_done = 0; m_cnt = 0; m_cnt3 = 0;
   endtask

   task automatic model_check();
      logic h, l2, l3;
      h  = ref_hold();
      l2 = lu_of({{(2*AW){1'b0}}, if_id_src}, {2'b00, if_id_src_used}, 2);
      l3 = lu_of({{AW{1'b0}}, if_id_src3}, {1'b0, if_id_src_used3}, 3);
      check("fwd",       forward_sel,  fwd_of({{(2*AW){1'b0}}, id_ex_src}, 2));
      check("stall_pc",  stall_pc,     h || l2);
      check("stall_ifid",stall_if_id,  h || l2);
      check("flush",     flush_id_ex,  l2 && !h);
      check("ex_hold",   ex_hold,      h);
      check("mul_busy",  mul_busy,     m_busy_left > 0);
      check("cnt",       stall_cycles, m_cnt);
      check("fwd3",      forward_sel3, fwd_of({{AW{1'b0}}, id_ex_src3}, 3));
      check("stall_pc3", stall_pc3,    h || l3);
      check("stall_ifid3", stall_if_id3, h || l3);
      check("flush3",    flush_id_ex3, l3 && !h);
      check("ex_hold3",  ex_hold3,     h);
      check("mul_busy3", mul_busy3,    m_busy_left > 0);
      check("cnt3",      stall_cycles3, m_cnt3);
   endtask

   task automatic model_step();
      logic h, s2, s3, st;
      if (rst) begin
         model_reset();
      end else begin
         st = ref_start();
         h  = ref_hold();
         s2 = h || lu_of({{(2*AW){1'b0}}, if_id_src}, {2'b00, if_id_src_used}, 2);
         s3 = h || lu_of({{AW{1'b0}}, if_id_src3}, {1'b0, if_id_src_used3}, 3);
         if (s2 && m_cnt < 65535) m_cnt++;
         if (s3 && m_cnt3 < 7) m_cnt3++;
         if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done = 1;
         end else if (st) begin
            m_busy_left = MS - 1;
         end else begin
            m_done = 0;
         end
      end
   endtask

   // called just after a falling edge with inputs already applied
   task automatic cycle();
      if (rst) model_reset();
      #1 model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      ex_mem_regwrite = 0; ex_mem_rd = 0; mem_wb_regwrite = 0; mem_wb_rd = 0;
      id_ex_src = 0; id_ex_memread = 0; id_ex_rd = 0; id_ex_mul = 0;
      if_id_src = 0; if_id_src_used = 0;
      id_ex_src3 = 0; if_id_src3 = 0; if_id_src_used3 = 0;
   endtask

   task automatic pulse_reset();
      idle();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   initial begin
      idle();
      model_reset();
      @(negedge clk);
      #1;
      check("rst_fwd", forward_sel, 4'b0000);
      check("rst_stall", stall_pc, 1'b0);
      check("rst_flush", flush_id_ex, 1'b0);
      check("rst_hold", ex_hold, 1'b0);
      check("rst_busy", mul_busy, 1'b0);
      check("rst_cnt", stall_cycles, 16'd0);
      rst = 0;
      @(negedge clk);

      // forwarding priority
      ex_mem_regwrite = 1; ex_mem_rd = 8; mem_wb_regwrite = 1; mem_wb_rd = 8;
      id_ex_src = {5'd9, 5'd8};
      #1;
      check("t1_op0", forward_sel[1:0], 2'b10);
      check("t1_op1", forward_sel[3:2], 2'b00);
      cycle();
      mem_wb_rd = 9;
      id_ex_src3 = {5'd9, 5'd0, 5'd8};
      #1;
      check("t1_op0_keep", forward_sel[1:0], 2'b10);
      check("t1_op1_wb", forward_sel[3:2], 2'b01);
      check("t1_three", forward_sel3, 6'b01_00_10);
      cycle();

      // register 0 is never forwarded
      ex_mem_rd = 0; mem_wb_rd = 0; id_ex_src = {5'd0, 5'd0};
      #1 check("t2_r0", forward_sel, 4'b0000);
      cycle();
      idle();

      // load-use
      id_ex_memread = 1; id_ex_rd = 5; if_id_src = {5'd5, 5'd3}; if_id_src_used = 2'b11;
      #1;
      check("t3_stall", stall_pc, 1'b1);
      check("t3_stall_ifid", stall_if_id, 1'b1);
      check("t3_flush", flush_id_ex, 1'b1);
      cycle();
      check("t3_cnt", stall_cycles, 16'd1);
      if_id_src_used = 2'b01;
      #1;
      check("t3_unused", stall_pc, 1'b0);
      check("t3_unused_flush", flush_id_ex, 1'b0);
      cycle();

      // multiply: two back-to-back sequences
      pulse_reset();
      id_ex_mul = 1;
      for (int k = 1; k <= 9; k++) begin
         #1;
         check($sformatf("t4_hold_%0d", k), ex_hold, (k <= 4) || (k >= 6));
         check($sformatf("t4_busy_%0d", k), mul_busy, (k inside {2, 3, 4, 7, 8, 9}));
         if (k == 5) check("t4_cnt", stall_cycles, 16'd4);
         if (k == 5) check("t4_nostall", stall_pc, 1'b0);
         cycle();
      end
      id_ex_mul = 0;
      cycle();
      cycle();

      // load-use during multiply
      pulse_reset();
      id_ex_mul = 1; id_ex_memread = 1; id_ex_rd = 5;
      if_id_src = {5'd5, 5'd3}; if_id_src_used = 2'b10;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check($sformatf("t5_flush_%0d", k), flush_id_ex, k == 5);
         check($sformatf("t5_hold_%0d", k), ex_hold, k <= 4);
         check($sformatf("t5_stall_%0d", k), stall_pc, 1'b1);
         cycle();
      end
      idle();
      cycle();

      // asynchronous reset in the second BUSY cycle, then a full restart
      pulse_reset();
      id_ex_mul = 1;
      cycle();
      cycle();
      #1 check("t6_pre_busy", mul_busy, 1'b1);
      rst = 1;
      #1;
      check("t6_busy", mul_busy, 1'b0);
      check("t6_hold", ex_hold, 1'b0);
      check("t6_cnt", stall_cycles, 16'd0);
      cycle();
      rst = 0;
      for (int k = 1; k <= 5; k++) begin
         #1 check($sformatf("t6_restart_%0d", k), ex_hold, k <= 4);
         cycle();
      end
      idle();
      cycle();

      // saturation of the 3-bit counter
      pulse_reset();
      id_ex_memread = 1; id_ex_rd = 5; if_id_src3 = {5'd0, 5'd0, 5'd5}; if_id_src_used3 = 3'b001;
      for (int k = 0; k < 10; k++) cycle();
      #1 check("t6_sat", stall_cycles3, 3'd7);
      idle();
      cycle();

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst             = ($urandom_range(0, 49) == 0);
         ex_mem_regwrite = $urandom_range(0, 1);
         mem_wb_regwrite = $urandom_range(0, 1);
         ex_mem_rd       = AW'($urandom_range(0, 3));
         mem_wb_rd       = AW'($urandom_range(0, 3));
         id_ex_rd        = AW'($urandom_range(0, 3));
         id_ex_memread   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) id_ex_mul = ~id_ex_mul;
         for (int i = 0; i < 2; i++) begin
            id_ex_src[i*AW +: AW] = AW'($urandom_range(0, 3));
            if_id_src[i*AW +: AW] = AW'($urandom_range(0, 3));
         end
         for (int i = 0; i < 3; i++) begin
            id_ex_src3[i*AW +: AW] = AW'($urandom_range(0, 3));
            if_id_src3[i*AW +: AW] = AW'($urandom_range(0, 3));
         end
         if_id_src_used  = 2'($urandom_range(0, 3));
         if_id_src_used3 = 3'($urandom_range(0, 7));
         cycle();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
